// File: rtl/serial_tx.sv
// Frame serialiser: start bit (0), DATA_W payload bits LSB first, stop bit (1),
// each held for CLKS_PER_BIT clocks; line idles high and is driven from a flop.
module serial_tx #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              busy
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] shift_q;
  logic              tx_q;
  logic              bit_end;

  assign bit_end  = (cnt_q == CNT_LAST);
  assign tx_ready = (state_q == IDLE) && !rst;
  assign busy     = (state_q != IDLE);
  assign tx_out   = tx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (tx_valid) begin
            state_q <= START;
            shift_q <= tx_data;
            cnt_q   <= '0;
            tx_q    <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state_q <= DATA;
            cnt_q   <= '0;
            idx_q   <= '0;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (idx_q == IDX_LAST) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              // Next bit is pre-shifted into bit 0 so the line flop always loads shift_q[0].
              idx_q   <= idx_q + IDX_W'(1);
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning payload bits per frame (legal range >= 1).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 4, meaning clk cycles per serial bit (legal range >= 1).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port tx_data  input  DATA_W  parallel word to transmit.
REQ-006 SHALL have port tx_valid  input  1  tx_data holds a word to send.
REQ-007 SHALL have port tx_ready  output  1  block can accept a word this cycle.
REQ-008 SHALL have port tx_out  output  1  serial line; idle level 1.
REQ-009 SHALL have port busy  output  1  a frame is in progress.

Function
REQ-010 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-011 SHALL drive tx_ready = 1 iff state is IDLE and rst is low; busy SHALL equal the inverse of (state == IDLE).
REQ-012 SHALL accept a word on a rising edge where tx_valid = 1 and tx_ready = 1; this is the only handshake condition.
REQ-013 SHALL capture tx_data into an internal shift register on acceptance; later tx_data changes SHALL NOT affect the frame.
REQ-014 SHALL move IDLE -> START on the acceptance edge, with tx_out = 0 from that edge.
REQ-015 SHALL hold START for exactly CLKS_PER_BIT cycles, then enter DATA.
REQ-016 SHALL in DATA send DATA_W bits LSB first; each bit SHALL be held on tx_out for exactly CLKS_PER_BIT cycles.
REQ-017 SHALL after the last data bit enter STOP with tx_out = 1 for exactly CLKS_PER_BIT cycles, then return to IDLE.
REQ-018 SHALL give a frame length of exactly (DATA_W+2)*CLKS_PER_BIT cycles from the acceptance edge to the IDLE re-entry edge.
REQ-019 SHALL spend at least one cycle in IDLE between frames, so back-to-back frames have exactly one extra idle-high cycle.
REQ-020 SHALL ignore tx_valid while state is not IDLE, with no queuing and no effect on the current frame.
REQ-021 SHALL drive tx_out from a register, glitch-free, with tx_out = 1 in IDLE.
REQ-022 SHALL size the bit-period counter ceil(log2(CLKS_PER_BIT)) bits (minimum 1) and the bit index ceil(log2(DATA_W)) bits (minimum 1).
REQ-023 SHALL handle CLKS_PER_BIT = 1 with no idle gaps inside a frame.
REQ-024 SHALL let rst take precedence over acceptance when both occur on the same edge; the word SHALL be dropped.

Reset
REQ-025 SHALL on any rising edge with rst = 1 set state to IDLE, clear counters and the shift register, and set tx_out = 1, busy = 0.
REQ-026 SHALL abort a frame in progress on reset mid-frame, with no further bits of that frame sent and the line high from the next edge.
REQ-027 SHALL hold tx_ready at 0 while rst = 1 and at 1 from the first cycle after rst deasserts.

Verification
REQ-028 SHALL verify reset: rst = 1 for 2 cycles, then 0 -> tx_out = 1, busy = 0, tx_ready = 1 on the first cycle after release.
REQ-029 SHALL verify a single frame (defaults): send 0xA5 -> tx_out = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, busy high for 40 cycles, then tx_ready = 1.
REQ-030 SHALL verify ignore-while-busy: hold tx_valid = 1 with tx_data = 0xFF from cycle 5 of a 0x00 frame -> 0x00 frame unaltered; 0xFF accepted on the first IDLE cycle after it.
REQ-031 SHALL verify back-to-back: tx_valid held high with 0x3C, then 0xC3 -> exactly one idle-high cycle between the stop bit of frame 1 and the start bit of frame 2.
REQ-032 SHALL verify reset mid-frame: rst pulsed 1 cycle during data bit 3 of 0x0F -> tx_out = 1 from the next edge, IDLE, no remaining bits emitted.
REQ-033 SHALL verify CLKS_PER_BIT = 1, DATA_W = 8: send 0x01 -> tx_out = 0,1,0,0,0,0,0,0,0,1 on 10 consecutive cycles.
